anton_neopixel_stream_logic: RTL and testbench
==============================================

Name: anton_neopixel_stream_logic

Overview:
Sequencer directly upstream of the NeoPixel bit-serialiser. Generates the state, pixelIndex, pixelBitIndex and bitPatternIndex the serialiser uses to turn pixel-buffer bytes into the NeoPixel waveform. Frames each strip update with a latch/reset gap and flags end-of-frame to the register/bus side. One 8-cycle bit pattern per colour bit at 7 MHz gives about 1.14 us per bit.

Parameters:
BUFFER_END, `BUFFER_END_DEFAULT, last valid byte index of the pixel buffer; BUFFER_BITS = `CLOG2(BUFFER_END+1)
RESET_DELAY, `RESET_DELAY_DEFAULT (600), clock cycles spent in RESET state per frame gap (>=50 us at 7 MHz)

Ports:
clk7mhz  input  1  system clock; all logic on rising edge
syncRst  input  1  synchronous, active-low reset
regCtrlRun  input  1  1 = stream enabled; 0 = abort and idle in RESET
regCtrl32bit  input  1  1 = 32-bit pixel format (stride 4); 0 = 8-bit (stride 1)
regPixelsMax  input  BUFFER_BITS  last buffer byte index to transmit (inclusive)
regCtrlLoop  input  1  continuous refresh (used only with the optional feature)
regCtrlInit  input  1  one-cycle pulse: start one frame (used only with the optional feature)
state  output  1  `ENUM_STATE_TRANSMIT or `ENUM_STATE_RESET
pixelIndex  output  BUFFER_BITS  byte index of the pixel being sent
pixelBitIndex  output  5  23..0, colour bit being sent, MSB first
bitPatternIndex  output  3  0..7, slot within the current bit pattern
streamSyncOf  output  1  one-cycle pulse on the last cycle of a frame's TRANSMIT
streamIdle  output  1  1 while parked in RESET, not counting

Behaviour:
- Reset (syncRst=0 at edge): state=RESET, pixelIndex=0, pixelBitIndex=23, bitPatternIndex=0, delay counter=0, latched32=0, streamSyncOf=0, streamIdle=1.
- All outputs are registered. Zero combinational paths from inputs to outputs.
- RESET state:
  - Run=1: delay counter increments each cycle, streamIdle=0.
  - At counter==RESET_DELAY-1: next cycle state=TRANSMIT, counter=0, latched32<=regCtrl32bit.
  - RESET therefore lasts exactly RESET_DELAY cycles.
- TRANSMIT state:
  - bitPatternIndex increments every cycle and wraps 7->0.
  - On wrap, pixelBitIndex decrements. At pixelBitIndex==0 it reloads 23 and the pixel advances.
- Pixel advance:
  - 8-bit mode: pixelIndex+1.
  - 32-bit mode: pixelIndex+4, with low 2 bits forced 00 throughout the frame.
- Last pixel:
  - 8-bit: pixelIndex >= min(regPixelsMax, BUFFER_END).
  - 32-bit: pixelIndex[BUFFER_BITS-1:2] >= regPixelsMax[BUFFER_BITS-1:2].
  - The >= comparison covers regPixelsMax lowered mid-frame. pixelIndex never overflows.
- On the final cycle of the last pixel (bit 0, slot 7):
  - streamSyncOf=1 for that cycle.
  - Next cycle: state=RESET, pixelIndex=0, pixelBitIndex=23, bitPatternIndex=0.
- regCtrl32bit is sampled only at TRANSMIT entry; toggling it mid-frame has no effect until the next frame. regPixelsMax is evaluated live.
- Run=0 at any point: next cycle state=RESET, all indices cleared, counter held at 0, streamIdle=1, no streamSyncOf.
  - Run back to 1: full RESET_DELAY gap, then the frame restarts from pixel 0 bit 23.
- Frame length = RESET_DELAY + Npix*192 cycles, where Npix = pixels sent.
- Without the optional feature, frames repeat indefinitely while Run=1.

Optional Feature:
ANTON_NEOPIXEL_ONESHOT_EN
- Defined:
  - regCtrlLoop=1: continuous refresh, as without the macro.
  - regCtrlLoop=0: after a frame's RESET gap completes, the block parks in RESET with streamIdle=1 and the counter saturated.
  - A regCtrlInit pulse (with Run=1) clears the counter and starts a new gap+frame.
  - regCtrlInit during TRANSMIT is ignored. regCtrlInit during the gap is remembered (pending flag), and transmission follows the gap.
- Undefined: regCtrlLoop and regCtrlInit are ignored; no pending-flag logic is generated.

Decomposition:
- anton_common.vh holds:
  - `ENUM_STATE_TRANSMIT / `ENUM_STATE_RESET
  - `BUFFER_END_DEFAULT
  - `CLOG2
  - new `RESET_DELAY_DEFAULT
  - the constant 23 as `PIXEL_BITS_LAST
- One sub-module is natural: anton_neopixel_reset_delay.
  - Counter of width `CLOG2(RESET_DELAY+1).
  - Inputs: enable, clear. Output: done.
  - Instantiated once.

Test Plan (bench: BUFFER_END=7, RESET_DELAY=4):
1. syncRst=0 for 3 cycles, Run=1 -> state=RESET, pixelIndex=0, pixelBitIndex=23, bitPatternIndex=0, streamSyncOf=0; after release, TRANSMIT exactly 4 cycles later.
2. 8-bit, regPixelsMax=2, Run=1 -> TRANSMIT for 576 cycles; pixelIndex 0,1,2; pixelBitIndex 23..0 per pixel; single streamSyncOf pulse at cycle 576; then 4 RESET cycles, repeat.
3. 32-bit, regPixelsMax=7 -> pixelIndex 0 then 4, 384 TRANSMIT cycles; toggling regCtrl32bit mid-frame leaves the stride at 4 until the next frame.
4. Run=0 at pixelIndex=1, pixelBitIndex=10 -> next cycle RESET, indices 0/23/0, streamIdle=1, no streamSyncOf; Run=1 -> 4 cycles later TRANSMIT from pixel 0 bit 23.
5. regPixelsMax lowered from 5 to 1 while pixelIndex=3 (8-bit) -> pixel 3 completes, then streamSyncOf and RESET.
6. ONESHOT_EN, Loop=0 -> one frame, gap, streamIdle=1 held for 50 cycles; regCtrlInit pulse -> 4-cycle gap then TRANSMIT from pixel 0.

Source files
------------

// File: rtl/anton_neopixel_stream_logic_pkg.sv
// anton_neopixel_stream_logic_pkg: shared state encodings, defaults and index limits for the NeoPixel sequencer
// Also carries the anton_common macros; optional one-shot feature macro: ANTON_NEOPIXEL_ONESHOT_EN
`ifndef ANTON_COMMON_VH
`define ANTON_COMMON_VH
`define ENUM_STATE_TRANSMIT 1'b1
`define ENUM_STATE_RESET 1'b0
`define BUFFER_END_DEFAULT 255
`define RESET_DELAY_DEFAULT 600
`define PIXEL_BITS_LAST 23
`define CLOG2(x) $clog2(x)
`endif
package anton_neopixel_stream_logic_pkg;
    localparam logic [0:0] STATE_TRANSMIT = `ENUM_STATE_TRANSMIT;
    localparam logic [0:0] STATE_RESET = `ENUM_STATE_RESET;
    localparam logic [4:0] PIXEL_BITS_LAST = 5'(`PIXEL_BITS_LAST);
    localparam logic [2:0] PATTERN_LAST = 3'd7;
endpackage

// File: rtl/anton_neopixel_reset_delay.sv
// anton_neopixel_reset_delay: frame-gap counter; done marks the last cycle of the gap
module anton_neopixel_reset_delay #(
    parameter int RESET_DELAY = `RESET_DELAY_DEFAULT
) (
    input  logic clk7mhz,
    input  logic syncRst,
    input  logic enable,
    input  logic clear,
    output logic done
);
    localparam int W = `CLOG2(RESET_DELAY + 1);
    logic [W-1:0] count;
    assign done = count == W'(RESET_DELAY - 1);
    always_ff @(posedge clk7mhz) begin
        if (!syncRst || clear) count <= '0;
        else if (enable) count <= done ? '0 : count + W'(1);
    end
endmodule

// File: rtl/anton_neopixel_stream_logic.sv
// anton_neopixel_stream_logic: state/pixel/bit/slot sequencer feeding the NeoPixel serialiser
// Optional one-shot framing enabled by defining ANTON_NEOPIXEL_ONESHOT_EN
module anton_neopixel_stream_logic
    import anton_neopixel_stream_logic_pkg::*;
#(
    parameter int BUFFER_END = `BUFFER_END_DEFAULT,
    parameter int RESET_DELAY = `RESET_DELAY_DEFAULT,
    localparam int BUFFER_BITS = `CLOG2(BUFFER_END + 1)
) (
    input  logic                   clk7mhz,
    input  logic                   syncRst,
    input  logic                   regCtrlRun,
    input  logic                   regCtrl32bit,
    input  logic [BUFFER_BITS-1:0] regPixelsMax,
    input  logic                   regCtrlLoop,
    input  logic                   regCtrlInit,
    output logic                   state,
    output logic [BUFFER_BITS-1:0] pixelIndex,
    output logic [4:0]             pixelBitIndex,
    output logic [2:0]             bitPatternIndex,
    output logic                   streamSyncOf,
    output logic                   streamIdle
);
    logic latched32, done, goTx, parked, initStart, lastPixel;
    logic [BUFFER_BITS-1:0] pixelsLast;
    assign pixelsLast = regPixelsMax > BUFFER_BITS'(BUFFER_END) ? BUFFER_BITS'(BUFFER_END) : regPixelsMax;
    assign lastPixel = latched32 ? pixelIndex[BUFFER_BITS-1:2] >= regPixelsMax[BUFFER_BITS-1:2]
                                 : pixelIndex >= pixelsLast;
`ifdef ANTON_NEOPIXEL_ONESHOT_EN
    logic pending;
    assign goTx = done && (regCtrlLoop || pending);
    assign initStart = parked && regCtrlInit;
    // An init seen during the gap is held until the gap ends; power-up sends one frame
    always_ff @(posedge clk7mhz) begin
        if (!syncRst) pending <= 1'b1;
        else if (regCtrlRun && state == STATE_RESET) pending <= goTx ? 1'b0 : pending || regCtrlInit;
    end
`else
    logic unusedCtrl;
    assign unusedCtrl = regCtrlLoop ^ regCtrlInit;
    assign goTx = done;
    assign initStart = 1'b0;
`endif
    assign parked = state == STATE_RESET && done && !goTx;
    anton_neopixel_reset_delay #(.RESET_DELAY(RESET_DELAY)) resetDelay (
        .clk7mhz(clk7mhz),
        .syncRst(syncRst),
        .enable (regCtrlRun && state == STATE_RESET && !parked),
        .clear  (!regCtrlRun || initStart),
        .done   (done)
    );
    // streamSyncOf is decided one slot early so the end-of-frame step agrees with the pulse
    always_ff @(posedge clk7mhz) begin
        if (!syncRst || !regCtrlRun) begin
            state <= STATE_RESET;
            pixelIndex <= '0;
            pixelBitIndex <= PIXEL_BITS_LAST;
            bitPatternIndex <= '0;
            streamSyncOf <= 1'b0;
            streamIdle <= 1'b1;
            if (!syncRst) latched32 <= 1'b0;
        end else if (state == STATE_RESET) begin
            streamSyncOf <= 1'b0;
            streamIdle <= parked && !initStart;
            if (goTx) begin
                state <= STATE_TRANSMIT;
                latched32 <= regCtrl32bit;
            end
        end else begin
            bitPatternIndex <= bitPatternIndex + 3'd1;
            streamSyncOf <= bitPatternIndex == 3'd6 && pixelBitIndex == '0 && lastPixel;
            if (bitPatternIndex == PATTERN_LAST) begin
                if (pixelBitIndex != '0) pixelBitIndex <= pixelBitIndex - 5'd1;
                else begin
                    pixelBitIndex <= PIXEL_BITS_LAST;
                    if (streamSyncOf) begin
                        state <= STATE_RESET;
                        pixelIndex <= '0;
                    end else pixelIndex <= pixelIndex + (latched32 ? BUFFER_BITS'(4) : BUFFER_BITS'(1));
                end
            end
        end
    end
endmodule

// File: tb/tb_anton_neopixel_stream_logic.sv
// tb_anton_neopixel_stream_logic: random and directed stimulus against a frame-time reference model
// Covers the one-shot behaviour too when ANTON_NEOPIXEL_ONESHOT_EN is defined
module tb_anton_neopixel_stream_logic;
    localparam int D = 4;
    logic clk7mhz = 1'b0, syncRst = 1'b0, regCtrlRun = 1'b1, regCtrl32bit = 1'b0;
    logic regCtrlLoop = 1'b1, regCtrlInit = 1'b0;
    logic [2:0] regPixelsMax = 3'd2;
    logic state, streamSyncOf, streamIdle;
    logic [2:0] pixelIndex, bitPatternIndex;
    logic [4:0] pixelBitIndex;
    int checks = 0, failures = 0;
    int mT = 0, mGap = 0, mStride = 1, txRun = 0, lastTx = 0, txDone = 0;
    bit mTx = 0, mSync = 0, mIdle = 1, mPending = 1;

    anton_neopixel_stream_logic #(.BUFFER_END(7), .RESET_DELAY(D)) dut (
        .clk7mhz(clk7mhz), .syncRst(syncRst), .regCtrlRun(regCtrlRun), .regCtrl32bit(regCtrl32bit),
        .regPixelsMax(regPixelsMax), .regCtrlLoop(regCtrlLoop), .regCtrlInit(regCtrlInit),
        .state(state), .pixelIndex(pixelIndex), .pixelBitIndex(pixelBitIndex),
        .bitPatternIndex(bitPatternIndex), .streamSyncOf(streamSyncOf), .streamIdle(streamIdle)
    );

    always #5 clk7mhz = ~clk7mhz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit lastPix(input int p);
        int mx = regPixelsMax;
        return mStride == 4 ? (p / 4) >= (mx / 4) : p >= (mx < 7 ? mx : 7);
    endfunction

    // Model: frame position is a single cycle count mT; pixel/bit/slot fall out by division
    task automatic modelStep();
        bit ready, go;
        if (!syncRst || !regCtrlRun) begin
            mTx = 0; mGap = 0; mT = 0; mSync = 0; mIdle = 1;
            if (!syncRst) mPending = 1;
        end else if (!mTx) begin
            ready = mGap == D - 1;
            go = ready;
`ifdef ANTON_NEOPIXEL_ONESHOT_EN
            go = ready && (regCtrlLoop || mPending);
            mIdle = ready && !go && !regCtrlInit;
            if (go) mPending = 0;
            else if (regCtrlInit) mPending = 1;
            if (ready && !go && regCtrlInit) mGap = 0;
            else if (!ready) mGap++;
`else
            mIdle = 0;
            if (!ready) mGap++;
`endif
            mSync = 0;
            if (go) begin
                mTx = 1; mGap = 0; mT = 0; mStride = regCtrl32bit ? 4 : 1;
            end
        end else if (mT % 192 == 191 && mSync) begin
            mTx = 0; mT = 0; mSync = 0;
        end else begin
            mT++;
            mSync = (mT % 192 == 191) && lastPix((mT / 192) * mStride);
        end
    endtask

    task automatic tick();
        @(posedge clk7mhz);
        modelStep();
        #1;
        check("state", state, mTx);
        check("pixelIndex", pixelIndex, mTx ? (mT / 192) * mStride : 0);
        check("pixelBitIndex", pixelBitIndex, mTx ? 23 - (mT % 192) / 8 : 23);
        check("bitPatternIndex", bitPatternIndex, mTx ? mT % 8 : 0);
        check("streamSyncOf", streamSyncOf, mSync);
        check("streamIdle", streamIdle, mIdle);
        if (state === 1'b1) txRun++;
        else if (txRun != 0) begin
            lastTx = txRun; txRun = 0; txDone++;
        end
    endtask

    task automatic waitFrameEnd(input string tag, input int expLen);
        int f = txDone;
        for (int i = 0; i < 6000 && txDone == f; i++) tick();
        check({tag, "_done"}, txDone - f, 1);
        check({tag, "_len"}, lastTx, expLen);
    endtask

    task automatic restart();
        regCtrlRun = 1'b0;
        tick();
        regCtrlRun = 1'b1;
    endtask

    initial begin
        repeat (3) tick();
        check("rst_state", state, 0);
        syncRst = 1'b1;
        repeat (D) tick();
        check("rst_first_tx", state, 1);
        restart();
        regCtrl32bit = 1'b0; regPixelsMax = 3'd2;
        waitFrameEnd("f8_a", 576);
        waitFrameEnd("f8_b", 576);
        regCtrlRun = 1'b0; regCtrl32bit = 1'b1; regPixelsMax = 3'd7;
        tick();
        regCtrlRun = 1'b1;
        for (int i = 0; i < 50 && state !== 1'b1; i++) tick();
        repeat (100) tick();
        regCtrl32bit = 1'b0;
        waitFrameEnd("f32", 384);
        restart();
        regPixelsMax = 3'd2;
        for (int i = 0; i < 3000 && !(mTx && mT / 192 == 1 && 23 - (mT % 192) / 8 == 10); i++) tick();
        check("abort_reach", pixelBitIndex, 10);
        regCtrlRun = 1'b0;
        tick();
        regCtrlRun = 1'b1;
        repeat (D) tick();
        check("abort_restart", state, 1);
        restart();
        regPixelsMax = 3'd5;
        for (int i = 0; i < 3000 && !(mTx && mT / 192 == 3); i++) tick();
        regPixelsMax = 3'd1;
        waitFrameEnd("lower_max", 768);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(399) == 0) regCtrlRun = 1'b0;
            else if ($urandom_range(7) == 0) regCtrlRun = 1'b1;
            if ($urandom_range(299) == 0) regPixelsMax = 3'($urandom_range(7));
            if ($urandom_range(199) == 0) regCtrl32bit = ~regCtrl32bit;
`ifdef ANTON_NEOPIXEL_ONESHOT_EN
            regCtrlInit = $urandom_range(99) == 0;
            if ($urandom_range(499) == 0) regCtrlLoop = ~regCtrlLoop;
`endif
            tick();
        end
`ifdef ANTON_NEOPIXEL_ONESHOT_EN
        regCtrlInit = 1'b0; regCtrlLoop = 1'b0; regCtrl32bit = 1'b0; regPixelsMax = 3'd1;
        restart();
        regCtrlInit = 1'b1;
        tick();
        regCtrlInit = 1'b0;
        waitFrameEnd("oneshot", 384);
        repeat (D + 50) tick();
        check("oneshot_idle", streamIdle, 1);
        check("oneshot_parked", state, 0);
        regCtrlInit = 1'b1;
        tick();
        regCtrlInit = 1'b0;
        repeat (D) tick();
        check("oneshot_init_tx", state, 1);
        waitFrameEnd("oneshot_b", 384);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
